// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result packer.
//   packer_state_t : packer FSM state encoding
//   DEF_*          : default widths / packing factor
//   lane_cnt_w()   : width of the lane counter for a given packing factor
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } packer_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PACK   = 4;
    localparam int DEF_ADDR_W = 6;

    function automatic int lane_cnt_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/pack_lane_counter.sv
// Modulo-PACK lane counter.
//   clk, rst (async, active-low)
//   en    : advance by one (wraps PACK-1 -> 0)
//   clr   : synchronous clear, has priority over en
//   count : current lane index
//   last  : count == PACK-1
module pack_lane_counter #(
    parameter int PACK   = 4,
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [LANE_W-1:0] count,
    output logic              last
);

    assign last = (count == LANE_W'(PACK - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + LANE_W'(1);
        end
    end

endmodule

// File: rtl/conv_result_packer.sv
// Packs PACK consecutive convolution results into one memory word and writes
// each full word at an auto-incrementing address. A finalize pulse flushes a
// partially filled word (zero-padded) and ends the run with a flush_done pulse.
//   clk, rst (async, active-low)
//   start, base_addr        : begin a run at base_addr (only from IDLE)
//   res_valid/res_data/res_ready : result handshake
//   finalize                : no more results; flush and finish
//   mem_wr_en/addr/data/ack : memory write handshake (request held until ack)
//   busy, flush_done, word_count : run status
// All outputs are decoded from registers; no input reaches an output
// combinationally.
module conv_result_packer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PACK   = DEF_PACK,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   res_valid,
    input  logic [DATA_W-1:0]      res_data,
    output logic                   res_ready,
    input  logic                   finalize,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [PACK*DATA_W-1:0] mem_wr_data,
    input  logic                   mem_wr_ack,
    output logic                   busy,
    output logic                   flush_done,
    output logic [ADDR_W:0]        word_count
);

    localparam int LANE_W = lane_cnt_w(PACK);

    packer_state_t          state;
    logic [LANE_W-1:0]      lane_cnt;
    logic                   lane_last;
    logic [PACK*DATA_W-1:0] pack_reg;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W:0]        words;
    logic                   pend_fin;

    logic accept;
    logic fin_seen;
    logic start_run;
    logic write_done;

    assign accept     = (state == COLLECT) && res_valid;
    // A finalize arriving this cycle counts as already latched so the flush
    // decision is not delayed by a cycle.
    assign fin_seen   = pend_fin || finalize;
    assign start_run  = (state == IDLE) && start;
    assign write_done = (state == WRITE) && mem_wr_ack;

    pack_lane_counter #(
        .PACK   (PACK),
        .LANE_W (LANE_W)
    ) u_lane_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clr   (start_run || write_done),
        .count (lane_cnt),
        .last  (lane_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pack_reg <= '0;
            addr     <= '0;
            words    <= '0;
            pend_fin <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        addr     <= base_addr;
                        words    <= '0;
                        pack_reg <= '0;
                        pend_fin <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (finalize) pend_fin <= 1'b1;
                    if (accept) begin
                        pack_reg[int'(lane_cnt)*DATA_W +: DATA_W] <= res_data;
                        // The accepted result leaves at least one lane filled,
                        // so a pending finalize always needs a write here.
                        if (lane_last || fin_seen) state <= WRITE;
                    end else if (fin_seen) begin
                        state <= (lane_cnt != '0) ? WRITE : DONE;
                    end
                end
                WRITE: begin
                    if (finalize) pend_fin <= 1'b1;
                    if (mem_wr_ack) begin
                        addr     <= addr + ADDR_W'(1);
                        words    <= words + (ADDR_W+1)'(1);
                        // Clearing here is what zero-pads a later partial word.
                        pack_reg <= '0;
                        state    <= fin_seen ? DONE : COLLECT;
                    end
                end
                DONE: begin
                    pend_fin <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_ready   = (state == COLLECT);
    assign mem_wr_en   = (state == WRITE);
    assign mem_wr_addr = addr;
    assign mem_wr_data = pack_reg;
    assign busy        = (state != IDLE);
    assign flush_done  = (state == DONE);
    assign word_count  = words;

endmodule

// File: tb/tb_conv_result_packer.sv
module tb_conv_result_packer;

    localparam int DATA_W = 8;
    localparam int PACK   = 4;
    localparam int ADDR_W = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic                   res_valid = 1'b0;
    logic [DATA_W-1:0]      res_data = '0;
    logic                   res_ready;
    logic                   finalize = 1'b0;
    logic                   mem_wr_en;
    logic [ADDR_W-1:0]      mem_wr_addr;
    logic [PACK*DATA_W-1:0] mem_wr_data;
    logic                   mem_wr_ack = 1'b0;
    logic                   busy;
    logic                   flush_done;
    logic [ADDR_W:0]        word_count;

    conv_result_packer #(
        .DATA_W (DATA_W),
        .PACK   (PACK),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .finalize    (finalize),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .busy        (busy),
        .flush_done  (flush_done),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [ADDR_W-1:0]      exp_addr_q[$];
    logic [PACK*DATA_W-1:0] exp_data_q[$];
    logic [ADDR_W:0]        exp_wc_q[$];

    int ack_delay = 0;
    int wait_cnt  = 0;
    int en_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model + scoreboard monitor, on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            mem_wr_ack = 1'b0;
            wait_cnt   = 0;
            en_cycles  = 0;
        end else begin
            if (mem_wr_en) begin
                en_cycles++;
                chk("ready_during_write", {63'd0, res_ready}, 64'd0);
                if (wait_cnt >= ack_delay) begin
                    mem_wr_ack = 1'b1;
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_write", 64'd1, 64'd0);
                    end else begin
                        chk("wr_addr", {58'd0, mem_wr_addr}, {58'd0, exp_addr_q.pop_front()});
                        chk("wr_data", {32'd0, mem_wr_data}, {32'd0, exp_data_q.pop_front()});
                    end
                    chk("wr_en_cycles", 64'(en_cycles), 64'(ack_delay + 1));
                    wait_cnt  = 0;
                    en_cycles = 0;
                end else begin
                    mem_wr_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_wr_ack = 1'b0;
                wait_cnt   = 0;
                en_cycles  = 0;
            end
            if (flush_done) begin
                if (exp_wc_q.size() == 0) begin
                    chk("unexpected_flush", 64'd1, 64'd0);
                end else begin
                    chk("flush_word_count", {57'd0, word_count}, {57'd0, exp_wc_q.pop_front()});
                end
                chk("flush_no_write", {63'd0, mem_wr_en}, 64'd0);
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Present a result and keep it until accepted; leaves res_valid high.
    task automatic send(input logic [DATA_W-1:0] d);
        logic r;
        res_valid = 1'b1;
        res_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            r = res_ready;
            @(posedge clk); #1;
            if (r) return;
        end
        chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drop_valid();
        res_valid = 1'b0;
    endtask

    task automatic do_finalize();
        finalize = 1'b1;
        @(posedge clk); #1;
        finalize = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_ready", {63'd0, res_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("rst_addr", {58'd0, mem_wr_addr}, 64'd0);
        chk("rst_data", {32'd0, mem_wr_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_flush", {63'd0, flush_done}, 64'd0);
        chk("rst_wc", {57'd0, word_count}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a stalled write
        ack_delay = 1000;
        do_start(6'd9);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        drop_valid();
        @(negedge clk);
        chk("pre_rst_wr_en", {63'd0, mem_wr_en}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, res_ready}, 64'd0);
        chk("midrst_addr", {58'd0, mem_wr_addr}, 64'd0);
        chk("midrst_data", {32'd0, mem_wr_data}, 64'd0);
        chk("midrst_wc", {57'd0, word_count}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ack_delay = 0;
        @(posedge clk); #1;

        // Start latency, then immediate finalize: no write, word_count 0
        do_start(6'd5);
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_ready", {63'd0, res_ready}, 64'd1);
        exp_wc_q.push_back(7'd0);
        do_finalize();
        chk("fin_done_pulse", {63'd0, flush_done}, 64'd1);
        chk("fin_done_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        chk("fin_done_low", {63'd0, flush_done}, 64'd0);
        chk("fin_idle", {63'd0, busy}, 64'd0);

        // Single word, ack tied high
        ack_delay = 0;
        exp_addr_q.push_back(6'd0); exp_data_q.push_back(32'h04030201);
        exp_wc_q.push_back(7'd1);
        do_start(6'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        drop_valid();
        do_finalize();
        wait_idle();

        // Two words, slow memory, valid held high
        ack_delay = 2;
        exp_addr_q.push_back(6'd0); exp_data_q.push_back(32'h04030201);
        exp_addr_q.push_back(6'd1); exp_data_q.push_back(32'h08070605);
        exp_wc_q.push_back(7'd2);
        do_start(6'd0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        drop_valid();
        do_finalize();
        wait_idle();

        // Partial word flush, zero padded
        ack_delay = 0;
        exp_addr_q.push_back(6'd0); exp_data_q.push_back(32'h04030201);
        exp_addr_q.push_back(6'd1); exp_data_q.push_back(32'h00000605);
        exp_wc_q.push_back(7'd2);
        do_start(6'd0);
        for (int i = 1; i <= 6; i++) send(8'(i));
        drop_valid();
        do_finalize();
        wait_idle();
        chk("wc_hold", {57'd0, word_count}, 64'd2);

        // Last result and finalize together: one write only
        exp_addr_q.push_back(6'd0); exp_data_q.push_back(32'h04030201);
        exp_wc_q.push_back(7'd1);
        do_start(6'd0);
        send(8'h01); send(8'h02); send(8'h03);
        res_valid = 1'b1;
        res_data  = 8'h04;
        finalize  = 1'b1;
        @(negedge clk);
        chk("fin_same_ready", {63'd0, res_ready}, 64'd1);
        @(posedge clk); #1;
        finalize = 1'b0;
        drop_valid();
        wait_idle();

        // Address wrap and start ignored while busy
        exp_addr_q.push_back(6'd63); exp_data_q.push_back(32'h04030201);
        exp_addr_q.push_back(6'd0);  exp_data_q.push_back(32'h08070605);
        exp_wc_q.push_back(7'd2);
        do_start(6'd63);
        send(8'h01); send(8'h02);
        drop_valid();
        do_start(6'd10);
        for (int i = 3; i <= 8; i++) send(8'(i));
        drop_valid();
        do_finalize();
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("writes_left", 64'(exp_addr_q.size()), 64'd0);
        chk("flushes_left", 64'(exp_wc_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_result_packer.md
# conv_result_packer

Downstream stage of the convolution controller/datapath: accepts one convolution result per handshake and packs PACK consecutive results into one memory word. It writes each full word to output memory at an auto-incrementing address. On finalize, it flushes a partially filled word zero-padded and reports completion. It owns the Z-side write address sequencing and memory write handshake, so the controller only issues result strobes and a finalize pulse.

## Interface
- DATA_W, 8, width of one convolution result
- PACK, 4, results per memory word (power of two, ≥2)
- ADDR_W, 6, output memory address width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low (clears all state while low)
- start  in  1  one-cycle pulse, begin a new output run; honoured only in IDLE
- base_addr  in  ADDR_W  first write address, sampled on start
- res_valid  in  1  res_data holds a new result
- res_data  in  DATA_W  convolution result
- res_ready  out  1  packer can accept a result this cycle
- finalize  in  1  one-cycle pulse, no more results; flush and finish
- mem_wr_en  out  1  write request, held until acked
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  PACK*DATA_W  packed word, lane 0 in bits [DATA_W-1:0]
- mem_wr_ack  in  1  memory accepted the write at this edge
- busy  out  1  high in any state except IDLE
- flush_done  out  1  one-cycle pulse when the run is complete
- word_count  out  ADDR_W+1  words written in the current run

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE → COLLECT on start.
  - Load base_addr into the address register.
  - Clear lane count, word_count, the pack register and the pending-finalize flag.
- COLLECT:
  - res_ready=1.
  - Accept on res_valid && res_ready: write res_data into lane[lane_cnt] and increment lane_cnt.
  - On the PACK-th accept, go to WRITE.
  - finalize is latched into pend_fin in any non-IDLE state.
  - With pend_fin set and no write outstanding: lane_cnt>0 → WRITE with unfilled lanes zero; lane_cnt=0 → DONE.
- WRITE:
  - res_ready=0, mem_wr_en=1; mem_wr_addr and mem_wr_data stay stable.
  - On mem_wr_ack: address +1 modulo 2^ADDR_W, word_count +1, lane_cnt and pack register cleared.
  - After the ack, go to DONE if pend_fin is set, else back to COLLECT.
- DONE: flush_done=1 for one cycle, pend_fin cleared, then IDLE. word_count holds its value until the next start.
- Simultaneous res_valid and finalize in COLLECT: the result is accepted first. If that accept fills the word, exactly one write occurs, followed by DONE, with no extra empty flush.
- finalize in IDLE is ignored. start outside IDLE is ignored.
- Reset mid-write: mem_wr_en drops asynchronously and the write is abandoned. The memory side must treat an unacked request as void.

## Timing
- Reset values:
  - Outputs: res_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, flush_done=0, word_count=0.
  - State: IDLE.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- start at edge t gives busy=1 and res_ready=1 from t+1.
- The PACK-th accept at edge t gives mem_wr_en=1 from t+1, with the complete word on mem_wr_data.
- With ack at edge t+k (k≥1, ack tied high gives k=1): mem_wr_en=0 and the next address at t+k+1, and res_ready=1 again at t+k+1.
- Minimum sustained rate: PACK results per PACK+1 cycles with zero-wait memory.
- Finalize with lane_cnt=0 at edge t: DONE at t+1, flush_done high for t+1 only, IDLE at t+2.
- Address wrap: after a write to 2^ADDR_W-1, the next address is 0. word_count saturates at 2^(ADDR_W)+... no, it wraps naturally at its ADDR_W+1 width.

## Structure
- Shared package conv_pkg:
  - State enum packer_state_t {IDLE, COLLECT, WRITE, DONE}.
  - Default DATA_W/PACK/ADDR_W constants.
  - The function computing lane-count width ($clog2(PACK)).
- One sub-module: pack_lane_counter.
  - Modulo-PACK counter with enable and synchronous clear.
  - Outputs: count, plus a last flag for count==PACK-1.
  - Asynchronous active-low reset on rst.
- Lane register and address/word counters live in the top module.

## Test plan
- Reset low mid-run → all outputs 0 immediately, state IDLE. After release, start with base_addr=5 → busy=1 next cycle.
- start, base_addr=0, results 1,2,3,4, ack tied high → one write: addr 0, data 0x04030201, mem_wr_en high exactly 1 cycle.
- 8 results, ack delayed 3 cycles per write → two writes at addr 0 and 1, data 0x04030201 and 0x08070605. res_ready=0 throughout each WRITE. No result lost while res_valid is held high.
- 6 results then finalize → writes 0x04030201 and 0x00000605, then flush_done pulse, word_count=2.
- 4th result and finalize in the same cycle → exactly one write, then flush_done. Immediate finalize after start → flush_done with no write, word_count=0.
- base_addr=63, 8 results (ADDR_W=6) → writes to 63 then 0. start pulsed while busy is ignored.
